pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/raw_cmp.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   pipe_state_e    : controller FSM states
//   DrainCycDefault : default number of drain cycles after an accepted HALT
//   cnt_width()     : width of the drain counter for a given drain length
package pipe_pkg;

    localparam int unsigned DrainCycDefault = 3;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StDrain   = 2'd2,
        StHalted  = 2'd3
    } pipe_state_e;

    // Counter must hold DRAIN_CYC itself; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cyc);
        return (cyc < 1) ? 1 : $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/raw_cmp.sv
// Read-after-write hazard detector for one ID source operand.
// Ports:
//   src, src_p       : source register number and "is read" flag
//   ex_rd, ex_rd_p   : destination and write flag of the ID/EX instruction
//   mem_rd, mem_rd_p : destination and write flag of the EX/MEM instruction
//   hit              : the source depends on an in-flight write
// Register 0 is compared like any other register.
module raw_cmp (
    input  logic [2:0] src,
    input  logic       src_p,
    input  logic [2:0] ex_rd,
    input  logic       ex_rd_p,
    input  logic [2:0] mem_rd,
    input  logic       mem_rd_p,
    output logic       hit
);

    assign hit = src_p && ((ex_rd_p && (src == ex_rd)) || (mem_rd_p && (src == mem_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt controller for a 5-stage in-order pipeline.
// Ports:
//   clk, rst                : clock; synchronous active-low reset
//   id_rs/id_rt (+_p)       : ID source registers and "is read" flags
//   ex_rd/mem_rd (+_p)      : in-flight destinations and "will write" flags
//   ex_br_taken             : EX resolves a taken branch/jump
//   id_halt                 : HALT instruction sits in ID
//   mem_busy                : data memory cannot complete this cycle
//   pc_en .. memwb_en       : PC and pipeline-register load enables
//   ifid_flush, idex_bubble : load NOP into IF/ID, ID/EX
//   halt_done               : registered, pipeline drained after HALT
//   stall_cnt               : saturating count of pc_en-low cycles (not HALTED)
// All outputs except halt_done and stall_cnt are combinational from state and inputs.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned DRAIN_CYC = DrainCycDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_p,
    input  logic        id_rt_p,
    input  logic [2:0]  ex_rd,
    input  logic [2:0]  mem_rd,
    input  logic        ex_rd_p,
    input  logic        mem_rd_p,
    input  logic        ex_br_taken,
    input  logic        id_halt,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        halt_done,
    output logic [15:0] stall_cnt
);

    localparam int unsigned CntW = cnt_width(DRAIN_CYC);

    pipe_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     stall_cnt_q;
    logic            halt_done_q;
    logic            raw_rs, raw_rt, raw_hazard;
    logic            stall_inc;

    raw_cmp u_raw_rs (
        .src      (id_rs),
        .src_p    (id_rs_p),
        .ex_rd    (ex_rd),
        .ex_rd_p  (ex_rd_p),
        .mem_rd   (mem_rd),
        .mem_rd_p (mem_rd_p),
        .hit      (raw_rs)
    );

    raw_cmp u_raw_rt (
        .src      (id_rt),
        .src_p    (id_rt_p),
        .ex_rd    (ex_rd),
        .ex_rd_p  (ex_rd_p),
        .mem_rd   (mem_rd),
        .mem_rd_p (mem_rd_p),
        .hit      (raw_rt)
    );

    assign raw_hazard = raw_rs || raw_rt;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        // While rst is low the defaults above are presented unchanged.
        if (rst) begin
            case (state_q)
                StRun, StMemWait: begin
                    if (mem_busy) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                        memwb_en = 1'b0;
                        state_d  = StMemWait;
                    end else begin
                        // Memory released: this cycle resolves like a RUN cycle.
                        state_d = StRun;
                        if (ex_br_taken) begin
                            ifid_flush  = 1'b1;
                            idex_bubble = 1'b1;
                        end else if (raw_hazard) begin
                            pc_en       = 1'b0;
                            ifid_en     = 1'b0;
                            idex_bubble = 1'b1;
                        end else if (id_halt) begin
                            // HALT itself moves on into ID/EX; fetch stops.
                            pc_en   = 1'b0;
                            ifid_en = 1'b0;
                            cnt_d   = CntW'(DRAIN_CYC);
                            state_d = StDrain;
                        end
                    end
                end

                StDrain: begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    if (mem_busy) begin
                        // Freeze everything, including the drain counter.
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                        memwb_en = 1'b0;
                    end else begin
                        idex_bubble = 1'b1;
                        cnt_d       = cnt_q - CntW'(1);
                        if (cnt_q <= CntW'(1)) begin
                            state_d = StHalted;
                        end
                    end
                end

                StHalted: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                end

                default: state_d = StRun;
            endcase
        end
    end

    assign stall_inc = !pc_en && (state_q != StHalted);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            halt_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_done_q <= (state_d == StHalted);
            if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign halt_done = halt_done_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver applies one directed vector per
// cycle and queues the hand-computed response; the monitor pops and compares on the
// falling edge.
module tb_pipe_hazard_ctrl;

    localparam logic [4:0] EnAll   = 5'b11111;
    localparam logic [4:0] EnNone  = 5'b00000;
    localparam logic [4:0] EnStall = 5'b00111;

    typedef struct {
        string      name;
        logic [4:0] en;
        int         fl;   // -1: not compared
        int         bu;   // -1: not compared
        logic       hd;
        int         sc;   // -1: not compared
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic        id_rs_p, id_rt_p, ex_rd_p, mem_rd_p;
    logic        ex_br_taken, id_halt, mem_busy;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_bubble, halt_done;
    logic [15:0] stall_cnt;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    pipe_hazard_ctrl #(
        .DRAIN_CYC (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_p     (id_rs_p),
        .id_rt_p     (id_rt_p),
        .ex_rd       (ex_rd),
        .mem_rd      (mem_rd),
        .ex_rd_p     (ex_rd_p),
        .mem_rd_p    (mem_rd_p),
        .ex_br_taken (ex_br_taken),
        .id_halt     (id_halt),
        .mem_busy    (mem_busy),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .halt_done   (halt_done),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Monitor: one expectation per cycle in which the driver queued one.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en} !== e.en) begin
                failures++;
                $display("FAIL %s enables got=%b want=%b", e.name,
                         {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, e.en);
            end
            if (e.fl >= 0) begin
                checks++;
                if (ifid_flush !== e.fl[0]) begin
                    failures++;
                    $display("FAIL %s ifid_flush got=%b want=%0d", e.name, ifid_flush, e.fl);
                end
            end
            if (e.bu >= 0) begin
                checks++;
                if (idex_bubble !== e.bu[0]) begin
                    failures++;
                    $display("FAIL %s idex_bubble got=%b want=%0d", e.name, idex_bubble, e.bu);
                end
            end
            checks++;
            if (halt_done !== e.hd) begin
                failures++;
                $display("FAIL %s halt_done got=%b want=%b", e.name, halt_done, e.hd);
            end
            if (e.sc >= 0) begin
                checks++;
                if (stall_cnt !== e.sc[15:0]) begin
                    failures++;
                    $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, stall_cnt, e.sc);
                end
            end
        end
    end

    task automatic idle();
        id_rs       = 3'd0;
        id_rt       = 3'd0;
        id_rs_p     = 1'b0;
        id_rt_p     = 1'b0;
        ex_rd       = 3'd0;
        mem_rd      = 3'd0;
        ex_rd_p     = 1'b0;
        mem_rd_p    = 1'b0;
        ex_br_taken = 1'b0;
        id_halt     = 1'b0;
        mem_busy    = 1'b0;
    endtask

    // RAW hazard on rs against the ID/EX destination.
    task automatic raw_ex3();
        id_rs   = 3'd3;
        id_rs_p = 1'b1;
        ex_rd   = 3'd3;
        ex_rd_p = 1'b1;
    endtask

    // Queue the response for the inputs currently applied, then advance one cycle.
    task automatic step(input string name, input logic [4:0] en, input int fl, input int bu,
                        input logic hd, input int sc);
        exp_t e;
        e.name = name;
        e.en   = en;
        e.fl   = fl;
        e.bu   = bu;
        e.hd   = hd;
        e.sc   = sc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // Reset cycles and plain running
        step("reset_a", EnAll, 0, 0, 1'b0, -1);
        step("reset_b", EnAll, 0, 0, 1'b0, 0);
        rst = 1'b1;
        step("normal", EnAll, 0, 0, 1'b0, 0);

        // Two-cycle RAW stall: EX match, then MEM match
        raw_ex3();
        step("raw_ex", EnStall, 0, 1, 1'b0, 0);
        ex_rd_p  = 1'b0;
        mem_rd   = 3'd3;
        mem_rd_p = 1'b1;
        step("raw_mem", EnStall, 0, 1, 1'b0, 1);
        idle();
        step("raw_clear", EnAll, 0, 0, 1'b0, 2);

        // rt operand, register 0 treated as an ordinary register
        id_rt_p  = 1'b1;
        mem_rd_p = 1'b1;
        step("raw_rt_r0", EnStall, 0, 1, 1'b0, 2);
        idle();
        id_rs   = 3'd5;
        ex_rd   = 3'd5;
        ex_rd_p = 1'b1;
        step("rs_not_read", EnAll, 0, 0, 1'b0, 3);
        id_rs_p = 1'b1;
        ex_rd   = 3'd4;
        step("rd_differs", EnAll, 0, 0, 1'b0, 3);

        // Branch overrides RAW and HALT
        idle();
        raw_ex3();
        ex_br_taken = 1'b1;
        step("br_over_raw", EnAll, 1, 1, 1'b0, 3);
        idle();
        ex_br_taken = 1'b1;
        id_halt     = 1'b1;
        step("br_over_halt", EnAll, 1, 1, 1'b0, 3);
        idle();
        step("after_br", EnAll, 0, 0, 1'b0, 3);

        // mem_busy for 4 cycles during a RAW hazard, then the stall resumes
        raw_ex3();
        mem_busy = 1'b1;
        step("busy_1", EnNone, 0, 0, 1'b0, 3);
        step("busy_2", EnNone, 0, 0, 1'b0, 4);
        step("busy_3", EnNone, 0, 0, 1'b0, 5);
        step("busy_4", EnNone, 0, 0, 1'b0, 6);
        mem_busy = 1'b0;
        step("raw_resume", EnStall, 0, 1, 1'b0, 7);
        idle();
        step("busy_raw_done", EnAll, 0, 0, 1'b0, 8);

        // mem_busy beats a branch; release cycle resolves the branch
        mem_busy    = 1'b1;
        ex_br_taken = 1'b1;
        step("busy_over_br", EnNone, 0, 0, 1'b0, 8);
        mem_busy = 1'b0;
        step("release_br", EnAll, 1, 1, 1'b0, 9);
        idle();
        step("release_done", EnAll, 0, 0, 1'b0, 9);

        // RAW beats HALT
        raw_ex3();
        id_halt = 1'b1;
        step("raw_over_halt", EnStall, 0, 1, 1'b0, 9);
        idle();
        step("no_drain", EnAll, 0, 0, 1'b0, 10);

        // Reset in the second DRAIN cycle; branch in DRAIN ignored
        id_halt = 1'b1;
        step("halt_accept_a", EnStall, 0, 0, 1'b0, 10);
        idle();
        ex_br_taken = 1'b1;
        step("drain_br_ignored", EnStall, 0, 1, 1'b0, 11);
        idle();
        rst = 1'b0;
        step("drain_reset", EnAll, 0, 0, 1'b0, 12);
        rst = 1'b1;
        step("after_drain_reset", EnAll, 0, 0, 1'b0, 0);

        // Full HALT drain, DRAIN_CYC=3
        id_halt = 1'b1;
        step("halt_accept_b", EnStall, 0, 0, 1'b0, 0);
        idle();
        step("drain_3", EnStall, 0, 1, 1'b0, 1);
        step("drain_2", EnStall, 0, 1, 1'b0, 2);
        step("drain_1", EnStall, 0, 1, 1'b0, 3);
        step("halted", EnNone, 0, 0, 1'b1, 4);
        id_halt  = 1'b1;
        mem_busy = 1'b1;
        step("halted_hold", EnNone, 0, 0, 1'b1, 4);
        idle();
        rst = 1'b0;
        step("halted_reset", EnAll, 0, 0, 1'b1, 4);
        rst = 1'b1;
        step("after_halt_reset", EnAll, 0, 0, 1'b0, 0);

        // HALT drain with one mem_busy cycle: halt_done one edge later
        id_halt = 1'b1;
        step("halt_accept_c", EnStall, 0, 0, 1'b0, 0);
        idle();
        step("drainb_3", EnStall, 0, 1, 1'b0, 1);
        mem_busy = 1'b1;
        step("drainb_busy", EnNone, 0, -1, 1'b0, 2);
        mem_busy = 1'b0;
        step("drainb_2", EnStall, 0, 1, 1'b0, 3);
        step("drainb_1", EnStall, 0, 1, 1'b0, 4);
        step("haltedb", EnNone, 0, 0, 1'b1, 5);

        // Saturation after 65540 RAW stall cycles
        rst = 1'b0;
        step("sat_reset", EnAll, 0, 0, 1'b1, 5);
        rst = 1'b1;
        raw_ex3();
        repeat (65540) @(posedge clk);
        #1;
        step("sat_a", EnStall, 0, 1, 1'b0, 16'hFFFF);
        step("sat_b", EnStall, 0, 1, 1'b0, 16'hFFFF);
        idle();
        step("sat_clear", EnAll, 0, 0, 1'b0, 16'hFFFF);

        // Let the monitor consume everything that was queued
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
